pipe_draw_scheduler: RTL and testbench
======================================

Name: pipe_draw_scheduler

Overview:
Per-frame sequencer that shares one pipe_drawer_top instance among NUM_PIPES pipes. On each frame_start it snapshots all pipe positions, then runs an erase pass over last frame's positions (colour 0), then a draw pass over the new positions (colour 1). It forwards the drawer's x/y stream to the framebuffer writer as qualified pixel writes. It sits between the game-state logic and the framebuffer port.

Parameters:
NUM_PIPES, 4, number of pipe slots; 2..8.
COORD_W, 11, coordinate width; must match the drawer.
DRAWER_LAT, 2, cycles from drw_enable rising to the first valid drw_x/drw_y.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle pulse at vblank
pipe_x_flat  in  NUM_PIPES*COORD_W  pipe i x at bits [i*COORD_W +: COORD_W]
pipe_y_flat  in  NUM_PIPES*COORD_W  pipe i y, same packing
pipe_valid  in  NUM_PIPES  slot i is on screen
drw_enable  out  1  drawer enable
drw_pipe_x  out  COORD_W  x of the pipe being drawn
drw_pipe_y  out  COORD_W  y of the pipe being drawn
drw_done  in  1  drawer done (combinational, one cycle)
drw_x, drw_y  in  COORD_W  drawer pixel coordinates
pixel_write  out  1  framebuffer write strobe
pixel_x, pixel_y  out  COORD_W  write address (pass-through of drw_x/drw_y)
pixel_color  out  1  0 = erase (background), 1 = pipe
busy  out  1  a frame is in progress
frame_done  out  1  one-cycle pulse when both passes are complete
overrun  out  1  one-cycle pulse when frame_start arrives while busy

Behaviour:
- Reset (asynchronous, reset==0):
  - state=IDLE; all outputs 0.
  - cur/prev snapshot registers and valid masks cleared; idx=0; pass=ERASE.
- States: IDLE, LATCH, SEL, RUN, TAIL, FINISH.
- IDLE:
  - frame_start -> LATCH.
- LATCH (1 cycle):
  - prev <= cur; prev_valid <= cur_valid.
  - cur <= pipe_x/y_flat; cur_valid <= pipe_valid.
  - idx=0; pass=ERASE; -> SEL.
  - Inputs are sampled only here. Mid-frame input changes have no effect.
- SEL (1 cycle per slot):
  - Selected mask is prev_valid in ERASE, cur_valid in DRAW.
  - If mask[idx]=1: load drw_pipe_x/y from the selected snapshot and go to RUN.
  - Otherwise advance.
  - Advance rule:
    - idx<NUM_PIPES-1: idx++.
    - Else in ERASE: pass=DRAW, idx=0.
    - Else in DRAW: -> FINISH.
- RUN:
  - drw_enable=1, held until drw_done is seen.
  - A latency counter counts from the RUN entry cycle (cycle 0).
  - pixel_write=1 in RUN cycles with counter>=DRAWER_LAT.
  - On drw_done: -> TAIL; drw_enable=0 from the next cycle.
- TAIL (1 cycle):
  - drw_enable=0; pixel_write=1, covering the drawer's final registered pixel.
  - Then apply the SEL advance rule and go to SEL or FINISH.
  - Guarantees the drawer idles with enable low for at least 1 cycle between pipes.
- FINISH (1 cycle):
  - frame_done=1; -> IDLE.
- pixel_x/pixel_y = drw_x/drw_y, combinational.
- pixel_color = (pass==DRAW), constant within a pass.
- busy=1 in every state except IDLE.
- overrun:
  - frame_start while busy -> overrun pulse the same cycle.
  - That frame_start is otherwise ignored: no restart, no snapshot.
- frame_start in the same cycle as FINISH counts as busy: overrun pulses.
- First frame after reset: prev_valid=0, so the erase pass is only NUM_PIPES SEL cycles with no drawer activity.
- Empty frame (all valid=0, prev empty): LATCH + 2*NUM_PIPES SEL + FINISH = 2*NUM_PIPES+2 cycles from frame_start to frame_done.
- Reset mid-RUN:
  - All state clears immediately; drw_enable drops asynchronously.
  - The drawer is reset by the same system reset.
- A drw_done seen outside RUN is ignored.
- Arithmetic: idx is $clog2(NUM_PIPES) bits. No coordinate arithmetic; coordinates pass through unmodified.

Decomposition:
- Shared package pipe_pkg:
  - sched_state_t enum (IDLE..FINISH)
  - pass_t enum (ERASE, DRAW)
  - COORD_W constant
  - COLOR_BG=0, COLOR_PIPE=1
- One natural sub-module, pipe_slot_snapshot:
  - Holds the cur/prev register banks and valid masks.
  - Performs the LATCH swap.
  - Muxes the (x, y, valid) of slot idx for the selected pass.
- Scheduler FSM, latency counter and pixel qualification remain in the top.

Test Plan:
- Reset, then one frame_start with pipe_valid=4'b0001, pipe0=(50,380), real drawer attached:
  - No erase writes.
  - Draw pass writes with pixel_color=1; first write is (pipe0 left, 0) at RUN cycle 2.
  - frame_done pulses once; busy falls the same cycle.
- Second frame_start with pipe0 moved to (40,380):
  - Erase pass writes the exact pixel set of (50,380) with colour 0, then the draw pass writes (40,380) with colour 1.
  - Pixel count of each pass equals the drawer's standalone count.
- pipe_valid=4'b1010, slots 1 and 3 = (200,300), (400,350):
  - Two RUN/TAIL sequences in slot order 1 then 3, each separated by ≥1 cycle of drw_enable=0.
  - Slots 0 and 2 each take exactly 1 SEL cycle.
- All valid=0 on the first frame:
  - frame_done exactly 10 cycles after frame_start (NUM_PIPES=4).
  - drw_enable never rises.
- frame_start pulsed mid-RUN with pipe_x_flat changed the same cycle:
  - overrun pulses once.
  - The current frame completes using the old snapshot; the next frame's erase uses the old values.
- reset asserted mid-RUN, then released:
  - All outputs 0 within the same cycle; busy=0.
  - The next frame_start yields no erase writes.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe draw scheduler and its snapshot bank.
package pipe_pkg;

    localparam int COORD_W = 11;

    localparam logic COLOR_BG   = 1'b0;
    localparam logic COLOR_PIPE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SEL,
        RUN,
        TAIL,
        FINISH
    } sched_state_t;

    typedef enum logic {
        ERASE,
        DRAW
    } pass_t;

endpackage

// File: rtl/pipe_slot_snapshot.sv
// Current/previous frame register banks for all pipe slots, plus the
// per-slot mux that feeds the scheduler the slot under consideration.
module pipe_slot_snapshot #(
    parameter int NUM_PIPES = 4,
    parameter int COORD_W   = 11,
    parameter int IDX_W     = $clog2(NUM_PIPES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         latch,
    input  logic [NUM_PIPES*COORD_W-1:0] pipe_x_flat,
    input  logic [NUM_PIPES*COORD_W-1:0] pipe_y_flat,
    input  logic [NUM_PIPES-1:0]         pipe_valid,
    input  pipe_pkg::pass_t              pass,
    input  logic [IDX_W-1:0]             idx,
    output logic [COORD_W-1:0]           sel_x,
    output logic [COORD_W-1:0]           sel_y,
    output logic                         sel_valid
);
    import pipe_pkg::*;

    logic [NUM_PIPES*COORD_W-1:0] cur_x;
    logic [NUM_PIPES*COORD_W-1:0] cur_y;
    logic [NUM_PIPES*COORD_W-1:0] prev_x;
    logic [NUM_PIPES*COORD_W-1:0] prev_y;
    logic [NUM_PIPES-1:0]         cur_valid;
    logic [NUM_PIPES-1:0]         prev_valid;

    // The erase pass must target exactly what was drawn last frame, so the
    // outgoing snapshot moves to prev at the same edge the new one is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_x      <= '0;
            cur_y      <= '0;
            prev_x     <= '0;
            prev_y     <= '0;
            cur_valid  <= '0;
            prev_valid <= '0;
        end else if (latch) begin
            prev_x     <= cur_x;
            prev_y     <= cur_y;
            prev_valid <= cur_valid;
            cur_x      <= pipe_x_flat;
            cur_y      <= pipe_y_flat;
            cur_valid  <= pipe_valid;
        end
    end

    always_comb begin
        if (pass == DRAW) begin
            sel_x     = cur_x[idx*COORD_W +: COORD_W];
            sel_y     = cur_y[idx*COORD_W +: COORD_W];
            sel_valid = cur_valid[idx];
        end else begin
            sel_x     = prev_x[idx*COORD_W +: COORD_W];
            sel_y     = prev_y[idx*COORD_W +: COORD_W];
            sel_valid = prev_valid[idx];
        end
    end

endmodule

// File: rtl/pipe_draw_scheduler.sv
// Per-frame sequencer sharing one pipe drawer across all pipe slots: erase
// last frame's pipes, draw this frame's, and forward pixels to the framebuffer.
module pipe_draw_scheduler #(
    parameter int NUM_PIPES  = 4,
    parameter int COORD_W    = 11,
    parameter int DRAWER_LAT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic [NUM_PIPES*COORD_W-1:0] pipe_x_flat,
    input  logic [NUM_PIPES*COORD_W-1:0] pipe_y_flat,
    input  logic [NUM_PIPES-1:0]         pipe_valid,
    output logic                         drw_enable,
    output logic [COORD_W-1:0]           drw_pipe_x,
    output logic [COORD_W-1:0]           drw_pipe_y,
    input  logic                         drw_done,
    input  logic [COORD_W-1:0]           drw_x,
    input  logic [COORD_W-1:0]           drw_y,
    output logic                         pixel_write,
    output logic [COORD_W-1:0]           pixel_x,
    output logic [COORD_W-1:0]           pixel_y,
    output logic                         pixel_color,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);
    import pipe_pkg::*;

    localparam int IDX_W = $clog2(NUM_PIPES);
    localparam int CNT_W = $clog2(DRAWER_LAT + 2);

    sched_state_t      state, state_n;
    pass_t             pass, pass_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [CNT_W-1:0]  lat_cnt;
    logic              load_pipe;
    logic              last_slot;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic              sel_valid;

    pipe_slot_snapshot #(
        .NUM_PIPES (NUM_PIPES),
        .COORD_W   (COORD_W),
        .IDX_W     (IDX_W)
    ) u_snapshot (
        .clk         (clk),
        .reset       (reset),
        .latch       (state == LATCH),
        .pipe_x_flat (pipe_x_flat),
        .pipe_y_flat (pipe_y_flat),
        .pipe_valid  (pipe_valid),
        .pass        (pass),
        .idx         (idx),
        .sel_x       (sel_x),
        .sel_y       (sel_y),
        .sel_valid   (sel_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pass       <= ERASE;
            idx        <= '0;
            lat_cnt    <= '0;
            drw_pipe_x <= '0;
            drw_pipe_y <= '0;
        end else begin
            state <= state_n;
            pass  <= pass_n;
            idx   <= idx_n;
            // Saturating count of RUN cycles; zero on the RUN entry cycle.
            if (state != RUN) begin
                lat_cnt <= '0;
            end else if (lat_cnt < CNT_W'(DRAWER_LAT)) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (load_pipe) begin
                drw_pipe_x <= sel_x;
                drw_pipe_y <= sel_y;
            end
        end
    end

    assign last_slot = (idx == IDX_W'(NUM_PIPES - 1));

    always_comb begin
        state_n   = state;
        pass_n    = pass;
        idx_n     = idx;
        load_pipe = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_n = LATCH;
            end
            LATCH: begin
                idx_n   = '0;
                pass_n  = ERASE;
                state_n = SEL;
            end
            SEL, TAIL: begin
                if (state == SEL && sel_valid) begin
                    load_pipe = 1'b1;
                    state_n   = RUN;
                end else if (!last_slot) begin
                    idx_n   = idx + 1'b1;
                    state_n = SEL;
                end else if (pass == ERASE) begin
                    pass_n  = DRAW;
                    idx_n   = '0;
                    state_n = SEL;
                end else begin
                    state_n = FINISH;
                end
            end
            RUN: begin
                if (drw_done) state_n = TAIL;
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // TAIL still writes: the drawer's last pixel lands one cycle after done.
    assign drw_enable  = (state == RUN);
    assign pixel_write = ((state == RUN) && (lat_cnt >= CNT_W'(DRAWER_LAT))) || (state == TAIL);
    assign pixel_x     = drw_x;
    assign pixel_y     = drw_y;
    assign pixel_color = (pass == DRAW) ? COLOR_PIPE : COLOR_BG;
    assign busy        = (state != IDLE);
    assign frame_done  = (state == FINISH);
    assign overrun     = frame_start && (state != IDLE);

endmodule

// File: tb/tb_pipe_draw_scheduler.sv
// Self-checking bench: a small drawer stand-in plus a frame-level scoreboard
// that predicts every pixel write, frame timing, busy and overrun.
module tb_pipe_draw_scheduler;

    localparam int NP  = 4;
    localparam int CW  = 11;
    localparam int LAT = 2;
    localparam int NPIX = 5;

    typedef logic [2*CW:0] pix_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              frame_start = 1'b0;
    logic [NP*CW-1:0]  pipe_x_flat = '0;
    logic [NP*CW-1:0]  pipe_y_flat = '0;
    logic [NP-1:0]     pipe_valid = '0;
    logic              drw_enable;
    logic [CW-1:0]     drw_pipe_x, drw_pipe_y;
    logic              drw_done;
    logic [CW-1:0]     drw_x, drw_y;
    logic              pixel_write;
    logic [CW-1:0]     pixel_x, pixel_y;
    logic              pixel_color;
    logic              busy, frame_done, overrun;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    pipe_draw_scheduler #(.NUM_PIPES(NP), .COORD_W(CW), .DRAWER_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .pipe_x_flat(pipe_x_flat), .pipe_y_flat(pipe_y_flat), .pipe_valid(pipe_valid),
        .drw_enable(drw_enable), .drw_pipe_x(drw_pipe_x), .drw_pipe_y(drw_pipe_y),
        .drw_done(drw_done), .drw_x(drw_x), .drw_y(drw_y),
        .pixel_write(pixel_write), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_color(pixel_color), .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    // Pixel i of a pipe at (px,py): a short top row, then one pixel at (px,py).
    function automatic pix_t pixOf(input logic col, input logic [CW-1:0] px,
                                   input logic [CW-1:0] py, input int i);
        if (i < NPIX - 1) return {col, px + CW'(i), CW'(0)};
        return {col, px, py};
    endfunction

    // Drawer stand-in: pixel k appears LAT+k cycles after enable rises; done
    // fires one cycle before the final pixel.
    int dcnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) dcnt <= 0;
        else if (drw_enable) dcnt <= dcnt + 1;
        else dcnt <= 0;
    end

    always_comb begin
        pix_t p;
        p = '0;
        if (dcnt >= LAT) p = pixOf(1'b0, drw_pipe_x, drw_pipe_y, dcnt - LAT);
        drw_x    = p[2*CW-1:CW];
        drw_y    = p[CW-1:0];
        drw_done = drw_enable && (dcnt == LAT + NPIX - 2);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard state
    int          cyc = 0;
    logic        mBusy = 1'b0;
    logic        latchPending = 1'b0;
    int          acceptCyc, doneCyc, expEn, enCnt;
    logic [CW-1:0] mCurX [NP];
    logic [CW-1:0] mCurY [NP];
    logic          mCurV [NP];
    logic [CW-1:0] mPrevX [NP];
    logic [CW-1:0] mPrevY [NP];
    logic          mPrevV [NP];
    pix_t        expQ[$];
    // Per-frame statistics for the literal checks
    logic        haveFirst;
    int          firstOff, doneOff, cnt0, cnt1, rises, overrunCnt;
    pix_t        firstPix;
    logic        prevEnable = 1'b0, prevDone = 1'b0;

    always @(negedge clk) begin
        logic busyNow;
        cyc++;
        if (!reset) begin
            mBusy = 1'b0;
            latchPending = 1'b0;
            expQ.delete();
            for (int i = 0; i < NP; i++) begin
                mCurX[i] = '0; mCurY[i] = '0; mCurV[i] = 1'b0;
                mPrevX[i] = '0; mPrevY[i] = '0; mPrevV[i] = 1'b0;
            end
            prevEnable = 1'b0;
            prevDone = 1'b0;
        end else begin
            busyNow = mBusy;
            checkOutput("busy", 32'(busy), 32'(busyNow));
            checkOutput("overrun", 32'(overrun), 32'(frame_start && busyNow));
            checkOutput("frame_done", 32'(frame_done), 32'(busyNow && cyc == doneCyc));
            if (!busyNow) checkOutput("idle_enable", 32'(drw_enable), 32'(0));
            if (prevEnable && prevDone) checkOutput("enable_gap", 32'(drw_enable), 32'(0));
            if (pixel_write) begin
                if (!busyNow || expQ.size() == 0) begin
                    checkOutput("pixel_extra", 32'({pixel_color, pixel_x, pixel_y}), 32'(0));
                end else begin
                    checkOutput("pixel", 32'({pixel_color, pixel_x, pixel_y}), 32'(expQ.pop_front()));
                end
                if (!haveFirst) begin
                    haveFirst = 1'b1;
                    firstOff  = cyc - acceptCyc;
                    firstPix  = {pixel_color, pixel_x, pixel_y};
                end
                if (pixel_color) cnt1++; else cnt0++;
            end
            if (drw_enable) enCnt++;
            if (drw_enable && !prevEnable) rises++;
            if (overrun) overrunCnt++;
            prevEnable = drw_enable;
            prevDone   = drw_done;

            if (busyNow && cyc == doneCyc) begin
                checkOutput("pixels_left", 32'(expQ.size()), 32'(0));
                checkOutput("enable_cycles", 32'(enCnt), 32'(expEn));
                doneOff = cyc - acceptCyc;
                mBusy = 1'b0;
            end
            if (latchPending) begin
                int k;
                k = 0;
                for (int i = 0; i < NP; i++) begin
                    mPrevX[i] = mCurX[i]; mPrevY[i] = mCurY[i]; mPrevV[i] = mCurV[i];
                    mCurX[i]  = pipe_x_flat[i*CW +: CW];
                    mCurY[i]  = pipe_y_flat[i*CW +: CW];
                    mCurV[i]  = pipe_valid[i];
                end
                for (int i = 0; i < NP; i++)
                    if (mPrevV[i]) begin
                        k++;
                        for (int p = 0; p < NPIX; p++) expQ.push_back(pixOf(1'b0, mPrevX[i], mPrevY[i], p));
                    end
                for (int i = 0; i < NP; i++)
                    if (mCurV[i]) begin
                        k++;
                        for (int p = 0; p < NPIX; p++) expQ.push_back(pixOf(1'b1, mCurX[i], mCurY[i], p));
                    end
                doneCyc = acceptCyc + 2*NP + 2 + k*(LAT + NPIX);
                expEn   = k*(LAT + NPIX - 1);
                latchPending = 1'b0;
            end
            if (frame_start && !busyNow) begin
                mBusy = 1'b1;
                latchPending = 1'b1;
                acceptCyc = cyc;
                doneCyc = -1;
                haveFirst = 1'b0;
                firstOff = -1; doneOff = -1;
                cnt0 = 0; cnt1 = 0; rises = 0; enCnt = 0; overrunCnt = 0;
            end
        end
    end

    task automatic setPipe(input int slot, input int x, input int y);
        pipe_x_flat[slot*CW +: CW] = CW'(x);
        pipe_y_flat[slot*CW +: CW] = CW'(y);
    endtask

    task automatic applyStimulus(input logic [NP-1:0] valid);
        pipe_valid  = valid;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic waitFrameDone();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        if (!seen) checkOutput("frame_done_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
    endtask

    task automatic waitEnable();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            if (drw_enable) seen = 1'b1;
        end
        if (!seen) checkOutput("enable_timeout", 32'(0), 32'(1));
    endtask

    task automatic doReset();
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        doReset();
        checkOutput("reset_busy", 32'(busy), 32'(0));
        checkOutput("reset_enable", 32'(drw_enable), 32'(0));
        checkOutput("reset_write", 32'(pixel_write), 32'(0));

        // First frame: one pipe at (50,380); no erase, draw writes start at (50,0)
        setPipe(0, 50, 380);
        applyStimulus(4'b0001);
        waitFrameDone();
        checkOutput("t1_first_off", 32'(firstOff), 32'(9));
        checkOutput("t1_first_pix", 32'(firstPix), 32'({1'b1, 11'd50, 11'd0}));
        checkOutput("t1_cnt0", 32'(cnt0), 32'(0));
        checkOutput("t1_cnt1", 32'(cnt1), 32'(5));
        checkOutput("t1_done_off", 32'(doneOff), 32'(17));
        checkOutput("t1_busy_after", 32'(busy), 32'(0));

        // Pipe moves to (40,380): erase old position, draw new
        setPipe(0, 40, 380);
        applyStimulus(4'b0001);
        waitFrameDone();
        checkOutput("t2_first_pix", 32'(firstPix), 32'({1'b0, 11'd50, 11'd0}));
        checkOutput("t2_cnt0", 32'(cnt0), 32'(5));
        checkOutput("t2_cnt1", 32'(cnt1), 32'(5));
        checkOutput("t2_done_off", 32'(doneOff), 32'(24));

        // Slots 1 and 3 only, from a clean reset
        doReset();
        setPipe(0, 0, 0); setPipe(1, 200, 300); setPipe(2, 0, 0); setPipe(3, 400, 350);
        applyStimulus(4'b1010);
        waitFrameDone();
        checkOutput("t3_done_off", 32'(doneOff), 32'(24));
        checkOutput("t3_rises", 32'(rises), 32'(2));
        checkOutput("t3_first_pix", 32'(firstPix), 32'({1'b1, 11'd200, 11'd0}));
        checkOutput("t3_cnt1", 32'(cnt1), 32'(10));

        // Empty first frame
        doReset();
        applyStimulus(4'b0000);
        waitFrameDone();
        checkOutput("t4_done_off", 32'(doneOff), 32'(10));
        checkOutput("t4_rises", 32'(rises), 32'(0));

        // frame_start during RUN with changed inputs is an overrun and is ignored
        doReset();
        setPipe(0, 100, 200);
        applyStimulus(4'b0001);
        waitEnable();
        setPipe(0, 300, 200);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        waitFrameDone();
        checkOutput("t5_overrun_cnt", 32'(overrunCnt), 32'(1));
        checkOutput("t5_done_off", 32'(doneOff), 32'(17));
        checkOutput("t5_first_pix", 32'(firstPix), 32'({1'b1, 11'd100, 11'd0}));
        applyStimulus(4'b0001);
        waitFrameDone();
        checkOutput("t5_next_erase", 32'(firstPix), 32'({1'b0, 11'd100, 11'd0}));
        checkOutput("t5_next_cnt0", 32'(cnt0), 32'(5));

        // Reset mid-RUN clears everything immediately
        applyStimulus(4'b0001);
        waitEnable();
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        checkOutput("t6_enable", 32'(drw_enable), 32'(0));
        checkOutput("t6_write", 32'(pixel_write), 32'(0));
        checkOutput("t6_busy", 32'(busy), 32'(0));
        checkOutput("t6_done", 32'(frame_done), 32'(0));
        checkOutput("t6_pipe_x", 32'(drw_pipe_x), 32'(0));
        checkOutput("t6_pixel_x", 32'(pixel_x), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        applyStimulus(4'b0001);
        waitFrameDone();
        checkOutput("t6_cnt0", 32'(cnt0), 32'(0));
        checkOutput("t6_cnt1", 32'(cnt1), 32'(5));

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
